// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: operand forwarding, load-use stall, drives the ALU.
// Latency: 1 cycle. An instruction accepted at edge N is on out_* after edge N. All outputs are registered.
// Backpressure: holds while out_valid & !out_ready. in_ready drops on flush, on a load-use hazard, or when the stage is full.
// Ports:
//   clock, reset_n            - rising-edge clock, asynchronous active-low reset
//   flush                     - kills the held instruction (taken branch)
//   in_valid/in_ready, in_*   - decoded instruction from decode
//   ex_result                 - ALU result of the instruction currently held here
//   mem_rd_addr/_reg_write/_result - MEM-stage writeback, used for forwarding
//   out_valid/out_ready, out_* - registered instruction to the ALU
//   stall_count               - saturating count of load-use stall cycles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              in_branch_op,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [4:0]        mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_branch_op,
  output logic [DATA_W-1:0] out_operand_a,
  output logic [DATA_W-1:0] out_operand_b,
  output logic [DATA_W-1:0] out_store_data,
  output logic [4:0]        out_rd_addr,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [CNT_W-1:0]  stall_count
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              branch_op_q, branch_op_d;
  logic [DATA_W-1:0] operand_a_q, operand_a_d;
  logic [DATA_W-1:0] operand_b_q, operand_b_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic              hazard;
  logic              accept;
  logic              ex_fwd_rs1, ex_fwd_rs2, mem_fwd_rs1, mem_fwd_rs2;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    // A held load can only feed its consumer once it has reached MEM; rs2 is
    // irrelevant when the immediate replaces it.
    hazard = in_valid & valid_q & mem_read_q & reg_write_q & (rd_addr_q != 5'd0) &
             ((rd_addr_q == in_rs1_addr) | ((rd_addr_q == in_rs2_addr) & ~in_use_imm));

    // reset_n is folded in so decode never sees a ready while the stage is held in reset.
    in_ready = reset_n & ~flush & ~hazard & (~valid_q | out_ready);
    accept   = in_valid & in_ready;

    // EX forwarding excludes loads: their data is not in ex_result.
    ex_fwd_rs1  = valid_q & reg_write_q & ~mem_read_q & (rd_addr_q == in_rs1_addr) &
                  (in_rs1_addr != 5'd0);
    ex_fwd_rs2  = valid_q & reg_write_q & ~mem_read_q & (rd_addr_q == in_rs2_addr) &
                  (in_rs2_addr != 5'd0);
    mem_fwd_rs1 = mem_reg_write & (mem_rd_addr == in_rs1_addr) & (in_rs1_addr != 5'd0);
    mem_fwd_rs2 = mem_reg_write & (mem_rd_addr == in_rs2_addr) & (in_rs2_addr != 5'd0);

    fwd_rs1 = ex_fwd_rs1 ? ex_result : (mem_fwd_rs1 ? mem_result : in_rs1_data);
    fwd_rs2 = ex_fwd_rs2 ? ex_result : (mem_fwd_rs2 ? mem_result : in_rs2_data);
  end

  always_comb begin
    valid_d       = valid_q;
    alu_ctrl_d    = alu_ctrl_q;
    branch_op_d   = branch_op_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    store_data_d  = store_data_q;
    rd_addr_d     = rd_addr_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    stall_count_d = stall_count_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d      = 1'b1;
      alu_ctrl_d   = in_alu_ctrl;
      branch_op_d  = in_branch_op;
      operand_a_d  = fwd_rs1;
      operand_b_d  = in_use_imm ? in_imm : fwd_rs2;
      store_data_d = fwd_rs2;
      rd_addr_d    = in_rd_addr;
      reg_write_d  = in_reg_write;
      mem_read_d   = in_mem_read;
    end else if (valid_q & out_ready) begin
      valid_d = 1'b0;
    end

    if (hazard & ~flush & (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= 1'b0;
      alu_ctrl_q    <= '0;
      branch_op_q   <= 1'b0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      store_data_q  <= '0;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      alu_ctrl_q    <= alu_ctrl_d;
      branch_op_q   <= branch_op_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      store_data_q  <= store_data_d;
      rd_addr_q     <= rd_addr_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_ctrl   = alu_ctrl_q;
  assign out_branch_op  = branch_op_q;
  assign out_operand_a  = operand_a_q;
  assign out_operand_b  = operand_b_q;
  assign out_store_data = store_data_q;
  assign out_rd_addr    = rd_addr_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign stall_count    = stall_count_q;

endmodule
